// File: rtl/macc_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : macc_feeder
//  Description : Streams feature beats and the matching weight-RAM words into
//                a multiply-accumulate unit. A job is a number of dot products
//                of VEC_LEN beats each. The weight address is derived from the
//                beat/vector counters. Features and weights reach the MACC
//                aligned, two cycles after each accepted beat.
//                Optional feature: define MACC_FEEDER_PERF_EN to add the
//                stall_cnt performance counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module macc_feeder #(
  parameter int PARALLEL_IN  = 4,
  parameter int DATA1_WIDTH  = 16,
  parameter int DATA2_WIDTH  = 16,
  parameter int VEC_LEN      = 16,
  parameter int W_ADDR_WIDTH = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [7:0]                        num_vec,
  input  logic [PARALLEL_IN*DATA1_WIDTH-1:0] din,
  input  logic                              din_valid,
  output logic                              din_ready,
  output logic [W_ADDR_WIDTH-1:0]           w_addr,
  input  logic [PARALLEL_IN*DATA2_WIDTH-1:0] w_rdata,
  output logic [PARALLEL_IN*DATA1_WIDTH-1:0] dout1,
  output logic [PARALLEL_IN*DATA2_WIDTH-1:0] dout2,
  output logic                              dout_en,
  output logic                              dout_last,
  output logic                              busy,
  output logic                              done
`ifdef MACC_FEEDER_PERF_EN
  ,
  output logic [31:0]                       stall_cnt
`endif
);

  localparam int D1_W   = PARALLEL_IN * DATA1_WIDTH;
  localparam int D2_W   = PARALLEL_IN * DATA2_WIDTH;
  localparam int BEAT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(VEC_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Control state
  logic [1:0]        state_q, state_d;
  logic              flush_cnt_q, flush_cnt_d;
  logic [7:0]        num_vec_q, num_vec_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]        vec_cnt_q, vec_cnt_d;

  // Stage 1: beat accepted last cycle, waiting for the RAM read data
  logic [D1_W-1:0]   s1_din_q, s1_din_d;
  logic              s1_en_q, s1_en_d;
  logic              s1_last_q, s1_last_d;

  // Stage 2: aligned features/weights presented to the MACC
  logic [D1_W-1:0]   dout1_q, dout1_d;
  logic [D2_W-1:0]   dout2_q, dout2_d;
  logic              dout_en_q, dout_en_d;
  logic              dout_last_q, dout_last_d;

  // Decoded conditions
  logic w_accept;
  logic w_last_beat;
  logic w_last_vec;
  logic w_final;
  logic w_enter_run;

  // Beat handshake and end-of-vector / end-of-job detection
  always_comb begin
    w_accept    = din_valid && (state_q == S_RUN);
    w_last_beat = (beat_cnt_q == BEAT_LAST);
    w_last_vec  = (vec_cnt_q == (num_vec_q - 8'd1));
    w_final     = w_accept && w_last_beat && w_last_vec;
    w_enter_run = (state_q == S_IDLE) && start && (num_vec != 8'd0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM next-state logic; FLUSH lasts two cycles so the last beat drains
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_vec != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_final) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q) begin
          state_d     = S_DONE;
          flush_cnt_d = 1'b0;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        flush_cnt_d = 1'b0;
      end
    endcase
  end

  // FSM outputs, decoded from the current state only
  always_comb begin
    din_ready = (state_q == S_RUN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  // Job length capture and beat/vector counters
  always_comb begin
    num_vec_d  = num_vec_q;
    beat_cnt_d = beat_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      num_vec_d = num_vec;
    end
    if (w_enter_run) begin
      beat_cnt_d = '0;
      vec_cnt_d  = '0;
    end else if (w_accept) begin
      if (w_last_beat) begin
        beat_cnt_d = '0;
        vec_cnt_d  = w_last_vec ? 8'd0 : (vec_cnt_q + 8'd1);
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_vec_q  <= '0;
      beat_cnt_q <= '0;
      vec_cnt_q  <= '0;
    end else begin
      num_vec_q  <= num_vec_d;
      beat_cnt_q <= beat_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
    end
  end

  // Weight address; the product wraps naturally at W_ADDR_WIDTH bits
  always_comb begin
    w_addr = (W_ADDR_WIDTH'(vec_cnt_q) * W_ADDR_WIDTH'(VEC_LEN)) + W_ADDR_WIDTH'(beat_cnt_q);
  end

  // Two-stage alignment pipeline: stage 1 waits for the RAM read latency
  always_comb begin
    s1_en_d     = w_accept;
    s1_last_d   = w_accept && w_last_beat;
    s1_din_d    = w_accept ? din : s1_din_q;
    dout_en_d   = s1_en_q;
    dout_last_d = s1_last_q;
    dout1_d     = s1_en_q ? s1_din_q : dout1_q;
    dout2_d     = s1_en_q ? w_rdata  : dout2_q;
  end

  // Pipeline registers; a reset drops any beats still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_din_q    <= '0;
      s1_en_q     <= 1'b0;
      s1_last_q   <= 1'b0;
      dout1_q     <= '0;
      dout2_q     <= '0;
      dout_en_q   <= 1'b0;
      dout_last_q <= 1'b0;
    end else begin
      s1_din_q    <= s1_din_d;
      s1_en_q     <= s1_en_d;
      s1_last_q   <= s1_last_d;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
      dout_en_q   <= dout_en_d;
      dout_last_q <= dout_last_d;
    end
  end

  // MACC-facing outputs come straight from the stage-2 registers
  always_comb begin
    dout1     = dout1_q;
    dout2     = dout2_q;
    dout_en   = dout_en_q;
    dout_last = dout_last_q;
  end

`ifdef MACC_FEEDER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count RUN cycles starved of feature data, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_enter_run) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && !din_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Expose the stall count
  always_comb begin
    stall_cnt = stall_cnt_q;
  end
`endif

endmodule
`default_nettype wire
